// File: rtl/serv_rf_ram_if_mh.sv
// serv_rf_ram_if_mh
//   Bit-serial to RF_WIDTH-bit RAM adapter for the SERV register file with
//   multiple hart contexts sharing one RAM and a configurable RAM read latency.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_hart                hart context, sampled with a request
//   i_rreq / i_wreq       read / write request pulses (accepted only when idle)
//   o_ready               pulse: serial phase starts next cycle
//   o_busy                transaction in progress
//   i_rreg0/1, i_wreg0/1  source / destination register indices
//   i_wen0/1, i_wdata0/1  serial write enables and data, LSB first
//   o_rdata0/1            serial read data, LSB first
//   o_waddr/o_wdata/o_wen RAM write port
//   o_raddr/o_ren/i_rdata RAM read port, data valid RD_LAT cycles after o_ren
module serv_rf_ram_if_mh #(
    parameter int RF_WIDTH  = 2,
    parameter int WITH_CSR  = 1,
    parameter int NUM_HARTS = 1,
    parameter int RD_LAT    = 1,
    parameter int RF_L2D    = $clog2(NUM_HARTS*(32+4*WITH_CSR)*32/RF_WIDTH)
) (
    input  logic                                             i_clk,
    input  logic                                             i_rst_n,
    input  logic [(NUM_HARTS > 1 ? $clog2(NUM_HARTS) : 1)-1:0] i_hart,
    input  logic                                             i_rreq,
    input  logic                                             i_wreq,
    output logic                                             o_ready,
    output logic                                             o_busy,
    input  logic [4+WITH_CSR:0]                              i_rreg0,
    input  logic [4+WITH_CSR:0]                              i_rreg1,
    input  logic [4+WITH_CSR:0]                              i_wreg0,
    input  logic [4+WITH_CSR:0]                              i_wreg1,
    input  logic                                             i_wen0,
    input  logic                                             i_wen1,
    input  logic                                             i_wdata0,
    input  logic                                             i_wdata1,
    output logic                                             o_rdata0,
    output logic                                             o_rdata1,
    output logic [RF_L2D-1:0]                                o_waddr,
    output logic [RF_WIDTH-1:0]                              o_wdata,
    output logic                                             o_wen,
    output logic [RF_L2D-1:0]                                o_raddr,
    output logic                                             o_ren,
    input  logic [RF_WIDTH-1:0]                              i_rdata
);

    localparam int CH   = 32 / RF_WIDTH;
    localparam int REGS = 32 + 4*WITH_CSR;
    localparam int HW   = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
    localparam int RW   = 5 + WITH_CSR;

    typedef enum logic [2:0] {
        IDLE, RD_PRIME, RD_STREAM, WR_ACK, WR_STREAM, WR_DRAIN
    } state_t;

    state_t r_state, w_next;

    logic [5:0]          r_cnt;
    logic [HW-1:0]       r_hart;
    logic [RW-1:0]       r_reg0, r_reg1;

    logic [RD_LAT-1:0]   r_rvld, r_rprt;
    logic [RF_WIDTH-1:0] r_rhold0, r_rsh0, r_rsh1;

    logic [RF_WIDTH-2:0] r_wsh0, r_wsh1;
    logic [RF_WIDTH-1:0] w_wfull0, w_wfull1;
    logic [RF_WIDTH-1:0] r_wbuf0, r_wbuf1;
    logic                r_pend0, r_pend1;
    logic [4:0]          r_wchunk, w_wchunk;
    logic                w_wdone;

    int unsigned         w_rchunk, w_rphase;
    logic                w_ren, w_rport;
    logic                w_rdv, w_rdp;

    function automatic logic [RF_L2D-1:0] f_addr(input logic [31:0] h,
                                                 input logic [31:0] r,
                                                 input logic [31:0] k);
        return RF_L2D'((h*REGS + r)*CH + k);
    endfunction

    // ---------------- state register ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_rreq)      w_next = RD_PRIME;   // read wins over a simultaneous write
                else if (i_wreq) w_next = WR_ACK;
            end
            RD_PRIME:  if (r_cnt == 6'(RD_LAT + 1))  w_next = RD_STREAM;
            RD_STREAM: if (r_cnt == 6'(RD_LAT + 33)) w_next = IDLE;
            WR_ACK:    w_next = WR_STREAM;
            WR_STREAM: if (r_cnt == 6'd32) w_next = WR_DRAIN;
            // Stay one extra cycle only when port 1 is still queued behind port 0.
            WR_DRAIN:  if (!(r_pend0 && r_pend1)) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        // Reads for chunk k issue at counts k*W (port 0) and k*W+1 (port 1),
        // which keeps the next chunk arriving just as the current one empties.
        w_rchunk = 32'(r_cnt) / RF_WIDTH;
        w_rphase = 32'(r_cnt) % RF_WIDTH;
        w_rport  = (w_rphase == 1);
        w_ren    = 1'b0;
        o_ready  = 1'b0;
        o_busy   = (r_state != IDLE);
        case (r_state)
            RD_PRIME: o_ready = (r_cnt == 6'(RD_LAT + 1));
            WR_ACK:   o_ready = 1'b1;
            default:  o_ready = 1'b0;
        endcase
        if ((r_state == RD_PRIME || r_state == RD_STREAM) &&
            w_rchunk < CH && w_rphase < 2)
            w_ren = 1'b1;
        o_ren   = w_ren;
        o_raddr = w_ren ? f_addr(32'(r_hart), 32'(w_rport ? r_reg1 : r_reg0), w_rchunk)
                        : '0;

        o_wen = r_pend0 | r_pend1;
        if (r_pend0) begin
            o_waddr = f_addr(32'(r_hart), 32'(r_reg0), 32'(r_wchunk));
            o_wdata = r_wbuf0;
        end else if (r_pend1) begin
            o_waddr = f_addr(32'(r_hart), 32'(r_reg1), 32'(r_wchunk));
            o_wdata = r_wbuf1;
        end else begin
            o_waddr = '0;
            o_wdata = '0;
        end

        o_rdata0 = r_rsh0[0];
        o_rdata1 = r_rsh1[0];
    end

    // ---------------- transaction counter and request capture ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_hart <= '0;
            r_reg0 <= '0;
            r_reg1 <= '0;
        end else begin
            r_cnt <= (r_state == IDLE) ? '0 : r_cnt + 6'd1;
            if (r_state == IDLE) begin
                if (i_rreq) begin
                    r_hart <= i_hart;
                    r_reg0 <= i_rreg0;
                    r_reg1 <= i_rreg1;
                end else if (i_wreq) begin
                    r_hart <= i_hart;
                    r_reg0 <= i_wreg0;
                    r_reg1 <= i_wreg1;
                end
            end
        end
    end

    // ---------------- read path ----------------
    assign w_rdv = r_rvld[RD_LAT-1];
    assign w_rdp = r_rprt[RD_LAT-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rvld   <= '0;
            r_rprt   <= '0;
            r_rhold0 <= '0;
            r_rsh0   <= '0;
            r_rsh1   <= '0;
        end else begin
            // Tags travel alongside the RAM so returning data is routed by port.
            r_rvld[0] <= w_ren;
            r_rprt[0] <= w_rport;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_rvld[i] <= r_rvld[i-1];
                r_rprt[i] <= r_rprt[i-1];
            end
            if (w_rdv && !w_rdp)
                r_rhold0 <= (r_reg0 == '0) ? '0 : i_rdata;
            // Port 0's chunk waits in r_rhold0 so both operands load together.
            if (w_rdv && w_rdp) begin
                r_rsh0 <= r_rhold0;
                r_rsh1 <= (r_reg1 == '0) ? '0 : i_rdata;
            end else begin
                r_rsh0 <= {1'b0, r_rsh0[RF_WIDTH-1:1]};
                r_rsh1 <= {1'b0, r_rsh1[RF_WIDTH-1:1]};
            end
        end
    end

    // ---------------- write path ----------------
    assign w_wfull0 = {i_wdata0, r_wsh0};
    assign w_wfull1 = {i_wdata1, r_wsh1};
    assign w_wdone  = (r_state == WR_STREAM) && ((32'(r_cnt) % RF_WIDTH) == 0);
    assign w_wchunk = 5'((32'(r_cnt) - 32'd1) / RF_WIDTH);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wsh0   <= '0;
            r_wsh1   <= '0;
            r_wbuf0  <= '0;
            r_wbuf1  <= '0;
            r_pend0  <= 1'b0;
            r_pend1  <= 1'b0;
            r_wchunk <= '0;
        end else begin
            if (r_state == WR_STREAM) begin
                r_wsh0 <= w_wfull0[RF_WIDTH-1:1];
                r_wsh1 <= w_wfull1[RF_WIDTH-1:1];
            end
            // A completed chunk overrides the pending flags: with W>=2 the
            // previous port-1 write has always finished by this edge.
            if (w_wdone) begin
                r_pend0  <= i_wen0 && (r_reg0 != '0);
                r_pend1  <= i_wen1 && (r_reg1 != '0);
                r_wbuf0  <= w_wfull0;
                r_wbuf1  <= w_wfull1;
                r_wchunk <= w_wchunk;
            end else if (r_pend0) begin
                r_pend0 <= 1'b0;
            end else if (r_pend1) begin
                r_pend1 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serv_rf_ram_if_mh.sv
module tb_serv_rf_ram_if_mh;

    localparam int W    = 8;
    localparam int CSR  = 1;
    localparam int NH   = 4;
    localparam int LAT  = 2;
    localparam int REGS = 32 + 4*CSR;
    localparam int CH   = 32 / W;
    localparam int L2D  = $clog2(NH*REGS*32/W);

    logic           clk = 1'b0;
    logic           rst_n;
    logic [1:0]     i_hart;
    logic           i_rreq, i_wreq;
    logic           o_ready, o_busy;
    logic [5:0]     i_rreg0, i_rreg1, i_wreg0, i_wreg1;
    logic           i_wen0, i_wen1, i_wdata0, i_wdata1;
    logic           o_rdata0, o_rdata1;
    logic [L2D-1:0] o_waddr, o_raddr;
    logic [W-1:0]   o_wdata, i_rdata;
    logic           o_wen, o_ren;

    always #5 clk = ~clk;

    serv_rf_ram_if_mh #(.RF_WIDTH(W), .WITH_CSR(CSR), .NUM_HARTS(NH), .RD_LAT(LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_hart(i_hart),
        .i_rreq(i_rreq), .i_wreq(i_wreq), .o_ready(o_ready), .o_busy(o_busy),
        .i_rreg0(i_rreg0), .i_rreg1(i_rreg1), .i_wreg0(i_wreg0), .i_wreg1(i_wreg1),
        .i_wen0(i_wen0), .i_wen1(i_wen1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
        .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
        .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wen(o_wen),
        .o_raddr(o_raddr), .o_ren(o_ren), .i_rdata(i_rdata)
    );

    // RAM model with registered read pipeline and a backdoor write port.
    logic [W-1:0]   mem   [0:(1<<L2D)-1];
    logic [W-1:0]   rpipe [0:LAT-1];
    logic           bd_we;
    logic [L2D-1:0] bd_addr;
    logic [W-1:0]   bd_data;

    always @(posedge clk) begin
        if (o_wen) mem[o_waddr] <= o_wdata;
        if (bd_we) mem[bd_addr] <= bd_data;
        rpipe[0] <= o_ren ? mem[o_raddr] : 'x;
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign i_rdata = rpipe[LAT-1];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int unsigned a;
        logic [W-1:0] d;
        int c;
    } wexp_t;

    logic [1:0] q_rd[$];
    wexp_t      q_wr[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned ea(input int h, input int r, input int k);
        return (h*REGS + r)*CH + k;
    endfunction

    task automatic preload(input int h, input int r, input logic [31:0] v);
        for (int k = 0; k < CH; k++) begin
            bd_addr = L2D'(ea(h, r, k));
            bd_data = v[k*W +: W];
            bd_we   = 1'b1;
            tick();
        end
        bd_we = 1'b0;
    endtask

    task automatic do_read(input int h, input int r0, input int r1,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input bit with_wreq);
        int cyc = 0, rdy_cyc = -1, nrdy = 0, nren = 0, nwen = 0, nboth = 0, end_cyc = -1;
        logic [1:0] ex;
        q_rd.delete();
        for (int i = 0; i < 32; i++) q_rd.push_back({e1[i], e0[i]});
        i_hart  = 2'(h);
        i_rreg0 = 6'(r0);
        i_rreg1 = 6'(r1);
        i_rreq  = 1'b1;
        i_wreq  = with_wreq;
        i_wreg0 = 6'(r0);
        i_wen0  = 1'b1;
        i_wdata0 = 1'b1;
        while (cyc < 80) begin
            tick();
            cyc++;
            i_rreq = 1'b0;
            i_wreq = with_wreq && (cyc == 5);   // must be ignored while busy
            if (o_ren && o_wen) nboth++;
            if (o_ren) nren++;
            if (o_wen) nwen++;
            if (o_ready) begin
                nrdy++;
                if (rdy_cyc < 0) rdy_cyc = cyc;
            end
            if (!o_busy) begin
                end_cyc = cyc;
                break;
            end
            if (cyc >= 3 + LAT && q_rd.size() > 0) begin
                ex = q_rd.pop_front();
                chk($sformatf("rd h%0d r%0d/%0d bit%0d", h, r0, r1, 31 - q_rd.size()),
                    {o_rdata1, o_rdata0}, ex);
            end
        end
        i_wreq = 1'b0;
        i_wen0 = 1'b0;
        chk($sformatf("rd h%0d ready_cycle", h), rdy_cyc, 2 + LAT);
        chk("rd ready_pulses", nrdy, 1);
        chk("rd ren_count", nren, 2*CH);
        chk("rd wen_count", nwen, 0);
        chk("rd ren_and_wen", nboth, 0);
        chk("rd bits_left", q_rd.size(), 0);
        chk("rd idle_cycle", end_cyc, 35 + LAT);
    endtask

    task automatic do_write(input int h, input int w0, input int w1,
                            input bit en0, input bit en1,
                            input logic [31:0] d0, input logic [31:0] d1);
        int cyc = 0, nren = 0, nwen = 0, nexp = 0, last = -1, end_cyc = -1, nrdy = 0, rdy_cyc = -1;
        bit p0 = en0 && (w0 != 0);
        bit p1 = en1 && (w1 != 0);
        wexp_t e;
        q_wr.delete();
        for (int k = 0; k < CH; k++) begin
            if (p0) begin
                e.a = ea(h, w0, k); e.d = d0[k*W +: W]; e.c = 2 + (k+1)*W;
                q_wr.push_back(e);
                last = e.c;
            end
            if (p1) begin
                e.a = ea(h, w1, k); e.d = d1[k*W +: W]; e.c = 2 + (k+1)*W + (p0 ? 1 : 0);
                q_wr.push_back(e);
                last = e.c;
            end
        end
        nexp = q_wr.size();
        i_hart  = 2'(h);
        i_wreg0 = 6'(w0);
        i_wreg1 = 6'(w1);
        i_wen0  = en0;
        i_wen1  = en1;
        i_wreq  = 1'b1;
        while (cyc < 80) begin
            tick();
            cyc++;
            i_wreq = 1'b0;
            if (o_ren) nren++;
            if (o_ready) begin
                nrdy++;
                if (rdy_cyc < 0) rdy_cyc = cyc;
            end
            if (o_wen) begin
                nwen++;
                if (q_wr.size() > 0) begin
                    e = q_wr.pop_front();
                    chk($sformatf("wr h%0d addr/data/cycle", h),
                        {32'(o_waddr), 16'(o_wdata), 16'(cyc)},
                        {e.a, 16'(e.d), 16'(e.c)});
                end
            end
            if (!o_busy) begin
                end_cyc = cyc;
                break;
            end
            if (cyc >= 2 && cyc <= 33) begin
                i_wdata0 = d0[cyc-2];
                i_wdata1 = d1[cyc-2];
            end
        end
        chk("wr ready_cycle", rdy_cyc, 1);
        chk("wr ready_pulses", nrdy, 1);
        chk("wr wen_count", nwen, nexp);
        chk("wr ren_count", nren, 0);
        if (nexp > 0) chk("wr idle_cycle", end_cyc, last + 1);
        else          chk("wr terminated", end_cyc > 0, 1'b1);
    endtask

    initial begin
        int nwen;
        rst_n = 1'b0;
        i_hart = '0; i_rreq = 0; i_wreq = 0;
        i_rreg0 = '0; i_rreg1 = '0; i_wreg0 = '0; i_wreg1 = '0;
        i_wen0 = 0; i_wen1 = 0; i_wdata0 = 0; i_wdata1 = 0;
        bd_we = 0; bd_addr = '0; bd_data = '0;
        #3;
        chk("reset ctrl", {o_ready, o_busy, o_wen, o_ren, o_rdata0, o_rdata1}, '0);
        chk("reset addr/data", {o_waddr, o_raddr, o_wdata}, '0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        preload(0, 5, 32'hDEADBEEF);
        preload(0, 6, 32'h12345678);
        do_read(0, 5, 6, 32'hDEADBEEF, 32'h12345678, 1'b0);

        // GPR + CSR write, both ports enabled
        do_write(0, 7, 33, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h0000FFFF);
        do_read(0, 7, 33, 32'hA5A5A5A5, 32'h0000FFFF, 1'b0);

        // x0: writes suppressed, reads forced to zero even with non-zero RAM
        preload(0, 0, 32'hFFFFFFFF);
        do_write(0, 0, 0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        do_read(0, 0, 5, 32'h0, 32'hDEADBEEF, 1'b0);

        // hart separation, single-port enables
        do_write(2, 1, 2, 1'b1, 1'b0, 32'h11111111, 32'hFFFFFFFF);
        do_write(3, 1, 1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h22222222);
        do_read(2, 1, 1, 32'h11111111, 32'h11111111, 1'b0);
        do_read(3, 1, 1, 32'h22222222, 32'h22222222, 1'b0);

        // same destination on both ports: port 1 lands last
        do_write(1, 9, 9, 1'b1, 1'b1, 32'hAAAAAAAA, 32'h55555555);
        do_read(1, 9, 9, 32'h55555555, 32'h55555555, 1'b0);

        // simultaneous read/write request: read served, write dropped
        do_read(0, 5, 6, 32'hDEADBEEF, 32'h12345678, 1'b1);

        // reset in the middle of a write stream, before any chunk completes
        i_hart = 2'd0; i_wreg0 = 6'd6; i_wreg1 = 6'd5; i_wen0 = 1; i_wen1 = 1;
        i_wdata0 = 0; i_wdata1 = 0;
        i_wreq = 1'b1;
        tick();
        i_wreq = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst busy", o_busy, 1'b0);
        chk("midrst wen/ren/ready", {o_wen, o_ren, o_ready}, 3'b000);
        tick();
        rst_n = 1'b1;
        nwen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (o_wen) nwen++;
        end
        i_wen0 = 0; i_wen1 = 0;
        chk("midrst late_wen", nwen, 0);
        chk("midrst idle", o_busy, 1'b0);
        do_read(0, 5, 6, 32'hDEADBEEF, 32'h12345678, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
